mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS datapath, successor to the single-cycle combinational control decoder. A Moore FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives per-state datapath strobes and handshakes with a unified instruction/data memory that may insert wait states. ALU-op width and multiply/divide latency are parametrised.

## Interface
- ALUOP_W, 4: alu_op width (≥3)
- MULDIV_LAT, 8: cycles spent in MULDIV state (≥2; used only with MC_CTRL_MULDIV_EN)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], sampled when ir_write=1
- funct  in  6  IR[5:0], sampled when ir_write=1
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a store
- i_or_d  out  1  address select: 0=PC, 1=ALUOut
- ir_write, pc_write, pc_write_cond, branch_ne  out  1 each  IR load, unconditional PC load, branch PC load, BNE polarity
- pc_src  out  2  0=ALU (PC+4), 1=ALUOut (branch target), 2=jump target, 3=rs
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  0=rt, 1=const 4, 2=imm, 3=imm<<2
- alu_op  out  ALUOP_W  0=ADD 1=SUB 2=AND 3=OR 4=SLT 5=LUI 6=FUNCT (ALU decodes funct), zero-extended
- sign_extend, mem_to_reg, reg_write, save_pc  out  1 each
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- md_start, hilo_write  out  1 each  mult/div start pulse, HI/LO load
- illegal  out  1  one-cycle pulse for an undecodable instruction
- instr_done  out  1  one-cycle pulse on an instruction's final cycle

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, MULDIV. Outputs are a function of the state plus the latched opcode/funct. Any output not listed for a state is 0.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. While mem_ready=0, stay in FETCH. When mem_ready=1, assert ir_write=1 and pc_write=1 with pc_src=0, latch opcode/funct, and go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD, sign_extend=1 (precompute branch target). An unsupported opcode or funct pulses illegal and returns to FETCH. Otherwise go to EXEC.
- EXEC, by class:
  - R-type: alu_src_a=1, alu_src_b=0, alu_op=FUNCT; then WB.
  - JR (funct 0x08): pc_write=1, pc_src=3; then FETCH.
  - MULT 0x18 / DIV 0x1A: md_start=1; then MULDIV.
  - ADDI 0x08, ADDIU 0x09, SLTI 0x0A: alu_src_b=2, sign_extend=1, alu_op ADD/ADD/SLT; then WB.
  - ANDI 0x0C, ORI 0x0D, LUI 0x0F: alu_src_b=2, sign_extend=0, alu_op AND/OR/LUI; then WB.
  - LW 0x23 / SW 0x2B: alu_src_a=1, alu_src_b=2, alu_op=ADD, sign_extend=1; then MEM.
  - BEQ 0x04 / BNE 0x05: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond=1, pc_src=1, branch_ne=(op==BNE); then FETCH.
  - J 0x02: pc_write=1, pc_src=2; then FETCH.
  - JAL 0x03: as J, plus reg_write=1, reg_dst=2, save_pc=1; then FETCH.
- MEM: mem_req=1, i_or_d=1, mem_write=(SW). Hold until mem_ready=1. Then LW goes to WB and SW goes to FETCH.
- WB: reg_write=1. R-type uses reg_dst=1. Immediates use reg_dst=0. LW uses reg_dst=0 and mem_to_reg=1. Then FETCH.
- MULDIV: count MULDIV_LAT cycles. Assert hilo_write in the last cycle, then go to FETCH.
- instr_done: asserted on the transition out of the final state back to FETCH. Not asserted on an illegal instruction.

## Timing
- Reset: while rst=1, every output is 0. The next state is FETCH and the latched opcode/funct are cleared to 0. Reset takes effect in any state, including mid-MEM and mid-MULDIV; the in-flight instruction is abandoned with no reg_write or hilo_write.
- Latency with zero-wait memory (FETCH counts as 1 cycle):
  - J/JAL/JR/BEQ/BNE: 3 cycles.
  - R-type, immediate, SW: 4 cycles.
  - LW: 5 cycles.
  - MULT/DIV: 3+MULDIV_LAT cycles.
- Each mem_ready=0 cycle during FETCH or MEM adds one cycle. mem_req stays high, and the address/mem_write stay stable until mem_ready.
- mem_ready outside FETCH/MEM is ignored.
- pc_write and ir_write in FETCH are asserted only in the mem_ready=1 cycle.

## Configuration
- MC_CTRL_MULDIV_EN defined: MULT/DIV are decoded, and the MULDIV state and its counter exist.
- MC_CTRL_MULDIV_EN undefined: funct 0x18/0x1A are illegal (pulse in DECODE), the MULDIV state and counter are absent, and md_start/hilo_write are tied to 0.

## Test plan
- Reset mid-MEM of LW with mem_ready=0: rst for 1 cycle -> all outputs 0 that cycle; next cycle FETCH with mem_req=1; reg_write never asserted.
- ADD (opcode 0, funct 0x20), zero-wait memory -> states FETCH→DECODE→EXEC→WB; WB cycle reg_write=1, reg_dst=1; instr_done on cycle 4.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEM -> 10 cycles total; mem_req/i_or_d held stable; WB has mem_to_reg=1.
- BNE (0x05) -> EXEC has pc_write_cond=1, branch_ne=1, alu_op=1, pc_src=1; done in 3 cycles. JAL (0x03) -> reg_dst=2, save_pc=1, pc_src=2.
- Opcode 0x3F -> illegal pulses in DECODE; no reg_write/pc_write in DECODE; FETCH next cycle; no instr_done.
- MULT with MULDIV_LAT=8 and macro on -> md_start in EXEC, hilo_write in the 8th MULDIV cycle, 11 cycles total. With macro off -> illegal pulse in DECODE.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and handshakes with a wait-stating memory.
// Define MC_CTRL_MULDIV_EN to decode MULT/DIV and add the MULDIV state with its latency counter.
module mc_ctrl #(
    parameter int ALUOP_W    = 4,
    parameter int MULDIV_LAT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               sign_extend,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               save_pc,
    output logic [1:0]         reg_dst,
    output logic               md_start,
    output logic               hilo_write,
    output logic               illegal,
    output logic               instr_done
);

    if (ALUOP_W < 3 || MULDIV_LAT < 2) begin : gParamCheck
        $error("mc_ctrl: ALUOP_W must be >= 3 and MULDIV_LAT >= 2");
    end

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(6);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
`ifdef MC_CTRL_MULDIV_EN
        ,
        MULDIV = 3'd5
`endif
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [5:0] opReg;
    logic [5:0] functReg;

    logic isRType, isJr, isMulDiv, isAluR;
    logic isImmSigned, isImmZero, isLw, isSw, isBranch, isJ, isJal, isLegal;

    // Instruction class decode works only on the latched IR fields
    always_comb begin
        isRType     = (opReg == 6'h00);
        isJr        = isRType && (functReg == 6'h08);
`ifdef MC_CTRL_MULDIV_EN
        isMulDiv    = isRType && (functReg == 6'h18 || functReg == 6'h1A);
`else
        isMulDiv    = 1'b0;
`endif
        isAluR      = isRType && (functReg inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                                   [6'h20:6'h27], 6'h2A, 6'h2B});
        isImmSigned = (opReg inside {6'h08, 6'h09, 6'h0A});
        isImmZero   = (opReg inside {6'h0C, 6'h0D, 6'h0F});
        isLw        = (opReg == 6'h23);
        isSw        = (opReg == 6'h2B);
        isBranch    = (opReg == 6'h04 || opReg == 6'h05);
        isJ         = (opReg == 6'h02);
        isJal       = (opReg == 6'h03);
        isLegal     = isAluR | isJr | isMulDiv | isImmSigned | isImmZero |
                      isLw | isSw | isBranch | isJ | isJal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            opReg    <= '0;
            functReg <= '0;
        end else begin
            state <= nextState;
            if (ir_write) begin
                opReg    <= opcode;
                functReg <= funct;
            end
        end
    end

`ifdef MC_CTRL_MULDIV_EN
    localparam int CNT_W = $clog2(MULDIV_LAT + 1);
    logic [CNT_W-1:0] mdCount;
    logic             mdLast;

    // Counter idles at zero so every MULDIV visit starts a fresh count
    always_ff @(posedge clk) begin
        if (rst || state != MULDIV) begin
            mdCount <= '0;
        end else begin
            mdCount <= mdCount + CNT_W'(1);
        end
    end

    assign mdLast = (mdCount == CNT_W'(MULDIV_LAT - 1));
`endif

    // Outputs are forced to zero for the whole reset cycle
    always_comb begin
        nextState     = state;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = ALU_ADD;
        sign_extend   = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        save_pc       = 1'b0;
        reg_dst       = 2'd0;
        md_start      = 1'b0;
        hilo_write    = 1'b0;
        illegal       = 1'b0;
        instr_done    = 1'b0;

        if (rst) begin
            nextState = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        nextState = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b   = 2'd3;
                    sign_extend = 1'b1;
                    if (isLegal) begin
                        nextState = EXEC;
                    end else begin
                        illegal   = 1'b1;
                        nextState = FETCH;
                    end
                end
                EXEC: begin
                    if (isJr) begin
                        pc_write   = 1'b1;
                        pc_src     = 2'd3;
                        instr_done = 1'b1;
                        nextState  = FETCH;
`ifdef MC_CTRL_MULDIV_EN
                    end else if (isMulDiv) begin
                        md_start  = 1'b1;
                        nextState = MULDIV;
`endif
                    end else if (isAluR) begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_FUNCT;
                        nextState = WB;
                    end else if (isImmSigned) begin
                        alu_src_b   = 2'd2;
                        sign_extend = 1'b1;
                        alu_op      = (opReg == 6'h0A) ? ALU_SLT : ALU_ADD;
                        nextState   = WB;
                    end else if (isImmZero) begin
                        alu_src_b = 2'd2;
                        alu_op    = (opReg == 6'h0C) ? ALU_AND :
                                    (opReg == 6'h0D) ? ALU_OR  : ALU_LUI;
                        nextState = WB;
                    end else if (isLw || isSw) begin
                        alu_src_a   = 1'b1;
                        alu_src_b   = 2'd2;
                        sign_extend = 1'b1;
                        nextState   = MEM;
                    end else if (isBranch) begin
                        alu_src_a     = 1'b1;
                        alu_op        = ALU_SUB;
                        pc_write_cond = 1'b1;
                        pc_src        = 2'd1;
                        branch_ne     = (opReg == 6'h05);
                        instr_done    = 1'b1;
                        nextState     = FETCH;
                    end else begin
                        pc_write   = 1'b1;
                        pc_src     = 2'd2;
                        reg_write  = isJal;
                        reg_dst    = isJal ? 2'd2 : 2'd0;
                        save_pc    = isJal;
                        instr_done = 1'b1;
                        nextState  = FETCH;
                    end
                end
                MEM: begin
                    mem_req   = 1'b1;
                    i_or_d    = 1'b1;
                    mem_write = isSw;
                    if (mem_ready) begin
                        instr_done = isSw;
                        nextState  = isSw ? FETCH : WB;
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = isAluR ? 2'd1 : 2'd0;
                    mem_to_reg = isLw;
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end
`ifdef MC_CTRL_MULDIV_EN
                MULDIV: begin
                    if (mdLast) begin
                        hilo_write = 1'b1;
                        instr_done = 1'b1;
                        nextState  = FETCH;
                    end
                end
`endif
                default: nextState = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected output vectors are queued per instruction, then compared.
module tb_mc_ctrl;

    localparam int ALUOP_W = 4;
    localparam int LAT     = 8;

    logic               clk;
    logic               rst;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               mem_ready;
    logic               mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0]         pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               sign_extend, mem_to_reg, reg_write, save_pc;
    logic [1:0]         reg_dst;
    logic               md_start, hilo_write, illegal, instr_done;

    mc_ctrl #(.ALUOP_W(ALUOP_W), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .sign_extend(sign_extend), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .save_pc(save_pc), .reg_dst(reg_dst), .md_start(md_start), .hilo_write(hilo_write),
        .illegal(illegal), .instr_done(instr_done)
    );

    typedef struct packed {
        logic       memReq, memWrite, iOrD, irWrite, pcWrite, pcWriteCond, branchNe;
        logic [1:0] pcSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluOp;
        logic       signExtend, memToReg, regWrite, savePc;
        logic [1:0] regDst;
        logic       mdStart, hiloWrite, illegal, instrDone;
    } outVec_t;

    typedef struct packed {
        logic    mr;
        outVec_t v;
    } step_t;

    step_t expQ[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outVec_t observed();
        outVec_t o;
        o = '{mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
              pc_src, alu_src_a, alu_src_b, alu_op, sign_extend, mem_to_reg, reg_write,
              save_pc, reg_dst, md_start, hilo_write, illegal, instr_done};
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit tbLegal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
`ifdef MC_CTRL_MULDIV_EN
            if (fn == 6'h18 || fn == 6'h1A) return 1'b1;
`endif
            return fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
                              6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B};
        end
        return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                          6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    endfunction

    function automatic int specLatency(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        if (!tbLegal(op, fn)) return -1;
        if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) return 3 + LAT + fw;
        if (op == 6'h00 && fn == 6'h08) return 3 + fw;
        if (op inside {6'h02, 6'h03, 6'h04, 6'h05}) return 3 + fw;
        if (op == 6'h23) return 5 + fw + mw;
        if (op == 6'h2B) return 4 + fw + mw;
        return 4 + fw;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Builds the expected cycle-by-cycle outputs and mem_ready drive for one instruction
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        outVec_t v;
        v = '0; v.memReq = 1; v.aluSrcB = 2'd1;
        repeat (fw) expQ.push_back({1'b0, v});
        v.irWrite = 1; v.pcWrite = 1;
        expQ.push_back({1'b1, v});
        v = '0; v.aluSrcB = 2'd3; v.signExtend = 1;
        if (!tbLegal(op, fn)) begin
            v.illegal = 1;
            expQ.push_back({rnd(), v});
            return;
        end
        expQ.push_back({rnd(), v});
        v = '0;
        if (op == 6'h00 && fn == 6'h08) begin
            v.pcWrite = 1; v.pcSrc = 2'd3; v.instrDone = 1;
            expQ.push_back({rnd(), v});
        end else if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
            v.mdStart = 1;
            expQ.push_back({rnd(), v});
            for (int i = 1; i <= LAT; i++) begin
                v = '0;
                if (i == LAT) begin v.hiloWrite = 1; v.instrDone = 1; end
                expQ.push_back({rnd(), v});
            end
        end else if (op == 6'h00) begin
            v.aluSrcA = 1; v.aluOp = 4'd6;
            expQ.push_back({rnd(), v});
            v = '0; v.regWrite = 1; v.regDst = 2'd1; v.instrDone = 1;
            expQ.push_back({rnd(), v});
        end else if (op == 6'h23 || op == 6'h2B) begin
            v.aluSrcA = 1; v.aluSrcB = 2'd2; v.signExtend = 1;
            expQ.push_back({rnd(), v});
            v = '0; v.memReq = 1; v.iOrD = 1; v.memWrite = (op == 6'h2B);
            repeat (mw) expQ.push_back({1'b0, v});
            v.instrDone = (op == 6'h2B);
            expQ.push_back({1'b1, v});
            if (op == 6'h23) begin
                v = '0; v.regWrite = 1; v.memToReg = 1; v.instrDone = 1;
                expQ.push_back({rnd(), v});
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            v.aluSrcA = 1; v.aluOp = 4'd1; v.pcWriteCond = 1; v.pcSrc = 2'd1;
            v.branchNe = (op == 6'h05); v.instrDone = 1;
            expQ.push_back({rnd(), v});
        end else if (op == 6'h02 || op == 6'h03) begin
            v.pcWrite = 1; v.pcSrc = 2'd2; v.instrDone = 1;
            if (op == 6'h03) begin v.regWrite = 1; v.regDst = 2'd2; v.savePc = 1; end
            expQ.push_back({rnd(), v});
        end else begin
            v.aluSrcB = 2'd2;
            case (op)
                6'h08, 6'h09: begin v.signExtend = 1; v.aluOp = 4'd0; end
                6'h0A:        begin v.signExtend = 1; v.aluOp = 4'd4; end
                6'h0C:        v.aluOp = 4'd2;
                6'h0D:        v.aluOp = 4'd3;
                default:      v.aluOp = 4'd5;
            endcase
            expQ.push_back({rnd(), v});
            v = '0; v.regWrite = 1; v.instrDone = 1;
            expQ.push_back({rnd(), v});
        end
    endtask

    // Pops up to maxSteps entries; opcode/funct only valid during FETCH, garbage afterwards
    task automatic runSteps(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input int maxSteps, output int doneAt);
        step_t   s;
        outVec_t o;
        int      n;
        n      = 0;
        doneAt = -1;
        while (expQ.size() > 0 && n < maxSteps) begin
            s = expQ.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            if (s.v.memReq && !s.v.iOrD) begin
                opcode = op; funct = fn;
            end else begin
                opcode = ~op; funct = ~fn;
            end
            #1;
            o = observed();
            n++;
            if (o.instrDone && doneAt < 0) doneAt = n;
            checkOutput($sformatf("%s cyc%0d", name, n), 32'(o), 32'(s.v));
        end
    endtask

    task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw);
        int doneAt;
        applyStimulus(op, fn, fw, mw);
        runSteps(name, op, fn, 1000, doneAt);
        checkOutput({name, " latency"}, 32'(doneAt), 32'(specLatency(op, fn, fw, mw)));
    endtask

    task automatic resetCycleCheck(input string name);
        outVec_t v;
        @(negedge clk);
        rst = 1; mem_ready = 0;
        #1;
        checkOutput({name, " all-zero"}, 32'(observed()), 32'h0);
        @(negedge clk);
        rst = 0; mem_ready = 0;
        #1;
        v = '0; v.memReq = 1; v.aluSrcB = 2'd1;
        checkOutput({name, " fetch after"}, 32'(observed()), 32'(v));
    endtask

    initial begin
        int doneAt;
        rst = 1; mem_ready = 1; opcode = 6'h23; funct = 6'h20;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset outputs", 32'(observed()), 32'h0);
        @(negedge clk);
        rst = 0; mem_ready = 0;

        runInstr("ADD",   6'h00, 6'h20, 0, 0);
        runInstr("LW",    6'h23, 6'h00, 2, 3);
        runInstr("BNE",   6'h05, 6'h11, 0, 0);
        runInstr("JAL",   6'h03, 6'h00, 0, 0);
        runInstr("ILLOP", 6'h3F, 6'h00, 0, 0);
        runInstr("SW",    6'h2B, 6'h00, 1, 2);
        runInstr("ADDI",  6'h08, 6'h3F, 0, 0);
        runInstr("SLTI",  6'h0A, 6'h00, 0, 0);
        runInstr("ANDI",  6'h0C, 6'h00, 0, 0);
        runInstr("ORI",   6'h0D, 6'h00, 1, 0);
        runInstr("LUI",   6'h0F, 6'h00, 0, 0);
        runInstr("BEQ",   6'h04, 6'h00, 0, 0);
        runInstr("J",     6'h02, 6'h00, 0, 0);
        runInstr("JR",    6'h00, 6'h08, 0, 0);
        runInstr("ILLFN", 6'h00, 6'h3F, 0, 0);
        runInstr("MULT",  6'h00, 6'h18, 0, 0);
        runInstr("DIV",   6'h00, 6'h1A, 1, 0);
        runInstr("SUB",   6'h00, 6'h22, 0, 0);

        // LW abandoned in MEM while memory is still stalling
        applyStimulus(6'h23, 6'h00, 0, 3);
        runSteps("LWRST", 6'h23, 6'h00, 5, doneAt);
        checkOutput("LWRST no done", 32'(doneAt), 32'hFFFF_FFFF);
        expQ.delete();
        resetCycleCheck("LWRST");

        // MULT abandoned mid-MULDIV (plain illegal decode when the feature is off)
        applyStimulus(6'h00, 6'h18, 0, 0);
        runSteps("MDRST", 6'h00, 6'h18, 5, doneAt);
        expQ.delete();
        resetCycleCheck("MDRST");

        runInstr("ADDIU", 6'h09, 6'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
